// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: IF/ID state encoding, opcode constants and the
// long-opcode classifier used by the fetch/decode boundary register.
package pipe_pkg;

    typedef enum logic [0:0] {
        S_OPC = 1'b0,
        S_IMM = 1'b1
    } state_e;

    localparam logic [3:0] LONG_OPC_HI = 4'hC;
    localparam logic [7:0] INT_OPC     = 8'hF8;

    // An opcode whose high nibble is LONG_OPC_HI is followed by an immediate byte.
    function automatic logic is_long_opc(input logic [7:0] opc);
        return (opc[7:4] == LONG_OPC_HI);
    endfunction

endpackage

// File: rtl/if_id_long_reg_if.sv
// Fetch-to-decode bus of the IF/ID register: fetched byte and PCs in,
// assembled instruction, PCs and status out.
interface if_id_long_reg_if;

    logic       stall_D;
    logic       flush_D;
    logic [7:0] instr_F;
    logic [7:0] pc_F;
    logic [7:0] pc_plus_1_F;
    logic [7:0] instr_D;
    logic [7:0] imm_D;
    logic [7:0] pc_D;
    logic [7:0] pc_plus_1_D;
    logic       valid_D;
    logic       imm_pending;

    modport master (
        output stall_D, flush_D, instr_F, pc_F, pc_plus_1_F,
        input  instr_D, imm_D, pc_D, pc_plus_1_D, valid_D, imm_pending
    );

    modport slave (
        input  stall_D, flush_D, instr_F, pc_F, pc_plus_1_F,
        output instr_D, imm_D, pc_D, pc_plus_1_D, valid_D, imm_pending
    );

endinterface

// File: rtl/if_id_long_reg.sv
// IF/ID register that assembles 1- or 2-byte instructions from a byte-wide fetch.
// Optional interrupt injection is enabled by defining IF_ID_INT_EN.
module if_id_long_reg
    import pipe_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
`ifdef IF_ID_INT_EN
    input  logic                    int_req,
`endif
    if_id_long_reg_if.slave         bus
);

    state_e     state_q, state_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] imm_q, imm_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] pc1_q, pc1_d;
    logic       valid_q, valid_d;

`ifdef IF_ID_INT_EN
    logic       int_req_q, int_req_d;
    logic       int_pend_q, int_pend_d;
    logic       int_rise_s;
`endif

    // Next-state and next-output computation; flush outranks stall.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
`ifdef IF_ID_INT_EN
        int_req_d  = int_req;
        int_rise_s = int_req & ~int_req_q;
        int_pend_d = int_pend_q | int_rise_s;
`endif
        if (bus.flush_D) begin
            state_d = S_OPC;
            instr_d = 8'h00;
            imm_d   = 8'h00;
            pc_d    = 8'h00;
            pc1_d   = 8'h00;
            valid_d = 1'b0;
        end else if (bus.stall_D) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_OPC: begin
`ifdef IF_ID_INT_EN
                    if (int_pend_q) begin
                        // Injected op replaces this fetch; return address is the dropped byte's PC.
                        instr_d    = INT_OPC;
                        imm_d      = 8'h00;
                        pc_d       = bus.pc_F;
                        pc1_d      = bus.pc_F;
                        valid_d    = 1'b1;
                        state_d    = S_OPC;
                        int_pend_d = int_rise_s;
                    end else begin
`endif
                        instr_d = bus.instr_F;
                        imm_d   = 8'h00;
                        pc_d    = bus.pc_F;
                        pc1_d   = bus.pc_plus_1_F;
                        if (is_long_opc(bus.instr_F)) begin
                            valid_d = 1'b0;
                            state_d = S_IMM;
                        end else begin
                            valid_d = 1'b1;
                            state_d = S_OPC;
                        end
`ifdef IF_ID_INT_EN
                    end
`endif
                end
                S_IMM: begin
                    // Opcode and its PC stay; only the immediate and the next PC advance.
                    imm_d   = bus.instr_F;
                    pc1_d   = bus.pc_plus_1_F;
                    valid_d = 1'b1;
                    state_d = S_OPC;
                end
                default: begin
                    state_d = S_OPC;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_OPC;
            instr_q <= 8'h00;
            imm_q   <= 8'h00;
            pc_q    <= 8'h00;
            pc1_q   <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
        end
    end

`ifdef IF_ID_INT_EN
    // Interrupt edge detector and pending latch; survives flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_req_q  <= 1'b0;
            int_pend_q <= 1'b0;
        end else begin
            int_req_q  <= int_req_d;
            int_pend_q <= int_pend_d;
        end
    end
`endif

    assign bus.instr_D     = instr_q;
    assign bus.imm_D       = imm_q;
    assign bus.pc_D        = pc_q;
    assign bus.pc_plus_1_D = pc1_q;
    assign bus.valid_D     = valid_q;
    assign bus.imm_pending = (state_q == S_IMM);

endmodule
